// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between instruction register/datapath and the multicycle controller.
// Counter signals exist only when CTRL_PERF_CNT_EN is defined.
interface multicycle_ctrl_fsm_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegSrc;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ResultSrc;
    logic [3:0] Flags;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] CycleCnt;
    logic [31:0] InstrCnt;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
        input  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
        input  ResultSrc, Flags, CycleCnt, InstrCnt
    );
    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
        output RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
        output ResultSrc, Flags, CycleCnt, InstrCnt
    );
`else
    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
        input  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
        input  ResultSrc, Flags
    );
    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
        output RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
        output ResultSrc, Flags
    );
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM-subset controller: Moore FSM, NZCV flags, condition gating.
// Optional perf counters (CycleCnt/InstrCnt) when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_cond;
    logic [3:0] r_flags;

    logic [3:0] w_cmd;
    logic       w_c, w_n, w_v, w_z, w_ge;
    logic       w_cond, w_arith, w_logic, w_nowrite, w_rd15;
    logic [1:0] w_flagw, w_alu_dec;
    logic       w_pcw, w_irw, w_adr, w_memw, w_regw;
    logic [1:0] w_srca, w_srcb, w_alu, w_res;

    assign w_cmd     = bus.Funct[4:1];
    assign w_c       = r_flags[3];
    assign w_n       = r_flags[2];
    assign w_v       = r_flags[1];
    assign w_z       = r_flags[0];
    assign w_ge      = (w_n == w_v);
    assign w_arith   = (w_cmd == 4'b0100) || (w_cmd == 4'b0010)
                    || (w_cmd == 4'b1010);
    assign w_logic   = (w_cmd == 4'b0000) || (w_cmd == 4'b1100);
    assign w_nowrite = (w_cmd == 4'b1010);
    assign w_rd15    = (bus.Rd == 4'd15);
    assign w_flagw   = {bus.Funct[0] & (w_arith | w_logic),
                        bus.Funct[0] & w_arith};

    // Condition field evaluated against the current flags register
    always_comb begin
        w_cond = 1'b0;
        case (bus.Cond)
            4'b0000: w_cond = w_z;
            4'b0001: w_cond = ~w_z;
            4'b0010: w_cond = w_c;
            4'b0011: w_cond = ~w_c;
            4'b0100: w_cond = w_n;
            4'b0101: w_cond = ~w_n;
            4'b0110: w_cond = w_v;
            4'b0111: w_cond = ~w_v;
            4'b1000: w_cond = w_c & ~w_z;
            4'b1001: w_cond = ~(w_c & ~w_z);
            4'b1010: w_cond = w_ge;
            4'b1011: w_cond = ~w_ge;
            4'b1100: w_cond = ~w_z & w_ge;
            4'b1101: w_cond = ~(~w_z & w_ge);
            4'b1110: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // ALU operation for data-processing execute states
    always_comb begin
        w_alu_dec = 2'b00;
        case (w_cmd)
            4'b0100: w_alu_dec = 2'b00;
            4'b0010: w_alu_dec = 2'b01;
            4'b1010: w_alu_dec = 2'b01;
            4'b0000: w_alu_dec = 2'b10;
            4'b1100: w_alu_dec = 2'b11;
            default: w_alu_dec = 2'b00;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // State, latched condition and flags register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cond  <= 1'b0;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cond <= w_cond;
            if ((r_state == S_EXECR || r_state == S_EXECI) && r_cond) begin
                if (w_flagw[1]) begin
                    r_flags[2] <= bus.ALUFlags[2];
                    r_flags[0] <= bus.ALUFlags[0];
                end
                if (w_flagw[0]) begin
                    r_flags[3] <= bus.ALUFlags[3];
                    r_flags[1] <= bus.ALUFlags[1];
                end
            end
        end
    end

    // Moore controls per state, writes gated by the latched condition
    always_comb begin
        w_pcw  = 1'b0;
        w_irw  = 1'b0;
        w_adr  = 1'b0;
        w_memw = 1'b0;
        w_regw = 1'b0;
        w_srca = 2'd0;
        w_srcb = 2'd0;
        w_alu  = 2'b00;
        w_res  = 2'd0;
        case (r_state)
            S_FETCH: begin
                w_irw  = 1'b1;
                w_pcw  = 1'b1;
                w_srca = 2'd1;
                w_srcb = 2'd2;
                w_res  = 2'd2;
            end
            S_DECODE: begin
                w_srca = 2'd1;
                w_srcb = 2'd2;
                w_res  = 2'd2;
            end
            S_MEMADR: w_srcb = 2'd1;
            S_MEMRD:  w_adr  = 1'b1;
            S_MEMWB: begin
                w_res  = 2'd1;
                w_regw = r_cond & ~w_nowrite;
                w_pcw  = r_cond & w_rd15;
            end
            S_MEMWR: begin
                w_adr  = 1'b1;
                w_memw = r_cond;
            end
            S_EXECR: w_alu = w_alu_dec;
            S_EXECI: begin
                w_srcb = 2'd1;
                w_alu  = w_alu_dec;
            end
            S_ALUWB: begin
                w_regw = r_cond & ~w_nowrite;
                w_pcw  = r_cond & w_rd15;
            end
            S_BRANCH: begin
                w_srcb = 2'd1;
                w_res  = 2'd2;
                w_pcw  = r_cond;
            end
            default: ;
        endcase
    end

    // Write enables held low while reset is asserted
    assign bus.PCWrite    = w_pcw & rst_n;
    assign bus.IRWrite    = w_irw & rst_n;
    assign bus.MemWrite   = w_memw & rst_n;
    assign bus.RegWrite   = w_regw & rst_n;
    assign bus.AdrSrc     = w_adr;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ALUControl = w_alu;
    assign bus.ResultSrc  = w_res;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Flags      = r_flags;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_cyc;
    logic [31:0] r_ins;

    // Cycle count and retired-instruction count (entries into FETCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= 32'd0;
            r_ins <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_next == S_FETCH)
                r_ins <= r_ins + 32'd1;
        end
    end

    assign bus.CycleCnt = r_cyc;
    assign bus.InstrCnt = r_ins;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level model plus per-cycle compare.
// Counter checks are compiled in when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic       chk_en = 1'b0;
    int         e_ph = 0;
    logic       e_irw, e_pcw, e_memw, e_regw;
    logic [1:0] e_alu;
    logic [3:0] e_flags;
    logic [1:0] m_op = 2'b00;
    logic [3:0] mflags = 4'b0000;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Architectural condition check, {C,N,V,Z}
    function automatic logic cond_ok(input logic [3:0] cd,
                                     input logic [3:0] f);
        logic c, n, v, z;
        c = f[3]; n = f[2]; v = f[1]; z = f[0];
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !(c && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // Per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("IRWrite", {31'd0, bus.IRWrite}, {31'd0, e_irw});
            chk("PCWrite", {31'd0, bus.PCWrite}, {31'd0, e_pcw});
            chk("MemWrite", {31'd0, bus.MemWrite}, {31'd0, e_memw});
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, e_regw});
            chk("ALUControl", {30'd0, bus.ALUControl}, {30'd0, e_alu});
            chk("Flags", {28'd0, bus.Flags}, {28'd0, e_flags});
            chk("ImmSrc", {30'd0, bus.ImmSrc}, {30'd0, m_op});
            chk("RegSrc", {30'd0, bus.RegSrc},
                {30'd0, m_op == 2'b01, m_op == 2'b10});
            if (e_ph <= 1) begin
                chk("ALUSrcA", {30'd0, bus.ALUSrcA}, 32'd1);
                chk("ALUSrcB", {30'd0, bus.ALUSrcB}, 32'd2);
                chk("ResultSrc", {30'd0, bus.ResultSrc}, 32'd2);
            end
            if (e_ph == 0)
                chk("AdrSrc", {31'd0, bus.AdrSrc}, 32'd0);
        end
    end

    // Runs one instruction; abort_at >= 0 pulls reset in that cycle
    task automatic run(input logic [3:0] cd, input logic [1:0] op,
                       input logic [5:0] fn, input logic [3:0] rd,
                       input logic [3:0] af, input int abort_at);
        logic ldr, str, dp, br, ok;
        logic [3:0] cmd;
        int n;
        bus.Cond = cd; bus.Op = op; bus.Funct = fn;
        bus.Rd = rd; bus.ALUFlags = af;
        m_op = op;
        cmd = fn[4:1];
        ldr = (op == 2'b01) && fn[0];
        str = (op == 2'b01) && !fn[0];
        dp  = (op == 2'b00);
        br  = (op == 2'b10);
        n = ldr ? 5 : (str || dp) ? 4 : br ? 3 : 2;
        ok = cond_ok(cd, mflags);
        for (int i = 0; i < n; i++) begin
            logic last;
            last = (i == n - 1);
            e_ph = i;
            e_irw = (i == 0);
            e_pcw = (i == 0)
                 || (last && ok && (br || ((ldr || dp) && rd == 4'd15)));
            e_memw = last && ok && str;
            e_regw = last && ok && (ldr || dp) && (cmd != 4'b1010);
            e_alu = (dp && i == 2) ? alu_of(cmd) : 2'b00;
            e_flags = mflags;
            if (i == abort_at) begin
                chk_en = 1'b0;
                #2;
                chk("abort_memw_before", {31'd0, bus.MemWrite},
                    {31'd0, e_memw});
                rst_n = 1'b0;
                #1;
                chk("abort_memw", {31'd0, bus.MemWrite}, 32'd0);
                chk("abort_pcw", {31'd0, bus.PCWrite}, 32'd0);
                chk("abort_irw", {31'd0, bus.IRWrite}, 32'd0);
                chk("abort_flags", {28'd0, bus.Flags}, 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                mflags = 4'b0000;
                chk_en = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            if (dp && i == 2 && ok && fn[0]) begin
                if (cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b0000,
                                4'b1100}) begin
                    mflags[2] = af[2];
                    mflags[0] = af[0];
                end
                if (cmd inside {4'b0100, 4'b0010, 4'b1010}) begin
                    mflags[3] = af[3];
                    mflags[1] = af[1];
                end
            end
        end
    endtask

    initial begin
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0;
        bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
        #2;
        chk("rst_pcw", {31'd0, bus.PCWrite}, 32'd0);
        chk("rst_irw", {31'd0, bus.IRWrite}, 32'd0);
        chk("rst_memw", {31'd0, bus.MemWrite}, 32'd0);
        chk("rst_regw", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_flags", {28'd0, bus.Flags}, 32'd0);
        chk("rst_srcb", {30'd0, bus.ALUSrcB}, 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
`ifdef CTRL_PERF_CNT_EN
        run(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, -1);
        run(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, -1);
        run(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, -1);
        run(4'hE, 2'b10, 6'b000000, 4'd0, 4'd0, -1);
        chk("lit_cyclecnt", bus.CycleCnt, 32'd15);
        chk("lit_instrcnt", bus.InstrCnt, 32'd4);
`endif
        // ADD R1,R2,R3
        run(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, -1);
        // LDR EQ with Z=0: condition fails
        run(4'h0, 2'b01, 6'b011001, 4'd2, 4'd0, -1);
        // STR AL
        run(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0, -1);
        // CMP imm, ALU reports Z
        run(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0001, -1);
        chk("lit_cmp_flags", {28'd0, bus.Flags}, 32'h1);
        // BEQ taken, BNE not taken
        run(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, -1);
        run(4'h1, 2'b10, 6'b000000, 4'd0, 4'd0, -1);
        // Undefined op
        run(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, -1);
        // ADDS to PC
        run(4'hE, 2'b00, 6'b001001, 4'd15, 4'b1111, -1);
        chk("lit_adds_flags", {28'd0, bus.Flags}, 32'hF);
        // BGT fails (Z=1), BLS passes
        run(4'hC, 2'b10, 6'b000000, 4'd0, 4'd0, -1);
        run(4'h9, 2'b10, 6'b000000, 4'd0, 4'd0, -1);
        // ADDS clearing flags, then ANDS
        run(4'hE, 2'b00, 6'b001001, 4'd4, 4'b0000, -1);
        chk("lit_clear_flags", {28'd0, bus.Flags}, 32'h0);
        run(4'hE, 2'b00, 6'b000001, 4'd5, 4'b1111, -1);
        chk("lit_ands_flags", {28'd0, bus.Flags}, 32'h5);
        // SUBS NE with Z=1: no flag update
        run(4'h1, 2'b00, 6'b000101, 4'd5, 4'b1010, -1);
        chk("lit_subs_fail", {28'd0, bus.Flags}, 32'h5);
        // ORR imm MI, then unlisted cmd with S
        run(4'h4, 2'b00, 6'b111000, 4'd6, 4'd0, -1);
        run(4'hE, 2'b00, 6'b000011, 4'd7, 4'b1111, -1);
        // CMP reg setting only C
        run(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000, -1);
        chk("lit_cmp_c", {28'd0, bus.Flags}, 32'h8);
        // Cond 1111 never passes
        run(4'hF, 2'b00, 6'b001000, 4'd8, 4'd0, -1);
        // LDR to PC
        run(4'hE, 2'b01, 6'b011001, 4'd15, 4'd0, -1);
        // STR aborted by reset in MEMWR
        run(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0, 3);
        run(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, -1);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
